// File: rtl/beat_pkg.sv
// Shared tempo-tracker types and default beat-interval limits (65 MHz camera clock).
// Latency: none, declarations only.
// Backpressure: none.
package beat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } tempo_state_t;

    // 240 BPM and 40 BPM at 65 MHz
    localparam int DEF_MIN_PERIOD = 16_250_000;
    localparam int DEF_MAX_PERIOD = 97_500_000;

endpackage

// File: rtl/interval_averager.sv
// Circular history of the last 2^AVG_LOG2 intervals with a running sum; period = sum >> AVG_LOG2.
// Latency: period updates on the clock edge that takes the push.
// Backpressure: none, one push per cycle accepted unconditionally; clear wins over push.
module interval_averager
    import beat_pkg::*;
#(
    parameter int PERIOD_WIDTH = 27,
    parameter int AVG_LOG2     = 2
) (
    input  logic                    clk_camera_in,
    input  logic                    rst_in,
    input  logic                    push_vld,
    input  logic [PERIOD_WIDTH-1:0] push_dat,
    input  logic                    clear,
    output logic [AVG_LOG2:0]       fill,
    output logic [PERIOD_WIDTH-1:0] period
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = PERIOD_WIDTH + AVG_LOG2;

    logic [PERIOD_WIDTH-1:0] hist [DEPTH];
    logic [AVG_LOG2-1:0]     wptr;
    logic [SUM_W-1:0]        sum;
    logic [SUM_W-1:0]        sum_next;

    // Slot under wptr is the oldest entry (or 0 while still filling).
    assign sum_next = sum + SUM_W'(push_dat) - SUM_W'(hist[wptr]);

    always_ff @(posedge clk_camera_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wptr   <= '0;
            sum    <= '0;
            fill   <= '0;
            period <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            wptr <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (push_vld) begin
            hist[wptr] <= push_dat;
            wptr       <= wptr + 1'b1;
            sum        <= sum_next;
            period     <= sum_next[SUM_W-1:AVG_LOG2];
            if (fill != (AVG_LOG2+1)'(DEPTH)) fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/beat_tempo_tracker.sv
// Turns baton beat pulses into an averaged period and a phase-aligned metronome tick.
// Latency: accept/period/valid outputs one cycle after the beat edge; lost_out one cycle after icnt hits MAX+1.
// Backpressure: none, every input edge is judged on the cycle it arrives.
module beat_tempo_tracker
    import beat_pkg::*;
#(
    parameter int PERIOD_WIDTH = 27,
    parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter int MAX_PERIOD   = DEF_MAX_PERIOD,
    parameter int AVG_LOG2     = 2
) (
    input  logic                    clk_camera_in,
    input  logic                    rst_in,
    input  logic                    beat_in,
    output logic [PERIOD_WIDTH-1:0] period_out,
    output logic                    period_valid_out,
    output logic                    beat_accepted_out,
    output logic                    beat_out,
    output logic                    lost_out
);

    localparam int                    DEPTH     = 1 << AVG_LOG2;
    localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_P = PERIOD_WIDTH'(MAX_PERIOD + 1);

    tempo_state_t            state;
    tempo_state_t            state_next;
    logic                    beat_in_q;
    logic [PERIOD_WIDTH-1:0] icnt;
    logic [PERIOD_WIDTH-1:0] ph;
    logic [PERIOD_WIDTH-1:0] quarter;
    logic                    recent_tick;
    logic                    beat_edge;
    logic                    timeout;
    logic                    accept;
    logic                    push_vld;
    logic                    clear;
    logic                    wrap;
    logic [AVG_LOG2:0]       fill;

    assign beat_edge = beat_in & ~beat_in_q;
    assign timeout   = (state != IDLE) && (icnt == TIMEOUT_P);
    assign accept    = beat_edge && !timeout && ((state == IDLE) || (icnt >= MIN_P));
    assign push_vld  = accept && (state != IDLE);
    assign clear     = timeout || (accept && (state == IDLE));
    assign quarter   = period_out >> 2;
    assign wrap      = (ph >= period_out - 1'b1);

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    state_next = ACQUIRE;
                ACQUIRE: if (fill == (AVG_LOG2+1)'(DEPTH - 1)) state_next = LOCKED;
                default: state_next = state;
            endcase
        end
    end

    interval_averager #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .AVG_LOG2     (AVG_LOG2)
    ) u_avg (
        .clk_camera_in (clk_camera_in),
        .rst_in        (rst_in),
        .push_vld      (push_vld),
        .push_dat      (icnt),
        .clear         (clear),
        .fill          (fill),
        .period        (period_out)
    );

    always_ff @(posedge clk_camera_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            beat_in_q         <= 1'b0;
            icnt              <= '0;
            period_valid_out  <= 1'b0;
            beat_accepted_out <= 1'b0;
            lost_out          <= 1'b0;
        end else begin
            state             <= state_next;
            beat_in_q         <= beat_in;
            period_valid_out  <= (state_next == LOCKED);
            beat_accepted_out <= accept;
            lost_out          <= timeout;
            if (accept) icnt <= PERIOD_WIDTH'(1);
            else if (icnt != TIMEOUT_P) icnt <= icnt + 1'b1;
        end
    end

    // A real beat landing just after a free-running tick re-aligns phase without a second tick.
    always_ff @(posedge clk_camera_in or posedge rst_in) begin
        if (rst_in) begin
            ph          <= '0;
            beat_out    <= 1'b0;
            recent_tick <= 1'b0;
        end else if ((state == LOCKED) && !timeout) begin
            beat_out <= wrap || (accept && !(recent_tick && (ph < quarter)));
            ph       <= (wrap || accept) ? '0 : ph + 1'b1;
            if (wrap) recent_tick <= 1'b1;
            else if (ph >= quarter) recent_tick <= 1'b0;
        end else begin
            ph          <= '0;
            beat_out    <= 1'b0;
            recent_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beat_tempo_tracker.sv
// Directed bench for beat_tempo_tracker with small periods (MIN 4, MAX 40, 4-deep average, 8-bit).
// Inputs change and outputs are sampled 1 ns after each falling clock edge.
module tb_beat_tempo_tracker;

    localparam int PW = 8;

    logic          clk_camera_in;
    logic          rst_in;
    logic          beat_in;
    logic [PW-1:0] period_out;
    logic          period_valid_out;
    logic          beat_accepted_out;
    logic          beat_out;
    logic          lost_out;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt = 0;
    int lost_cnt = 0;

    logic          acc_s, bo_s, pv_s;
    logic [PW-1:0] po_s;

    beat_tempo_tracker #(
        .PERIOD_WIDTH (PW),
        .MIN_PERIOD   (4),
        .MAX_PERIOD   (40),
        .AVG_LOG2     (2)
    ) dut (
        .clk_camera_in     (clk_camera_in),
        .rst_in            (rst_in),
        .beat_in           (beat_in),
        .period_out        (period_out),
        .period_valid_out  (period_valid_out),
        .beat_accepted_out (beat_accepted_out),
        .beat_out          (beat_out),
        .lost_out          (lost_out)
    );

    initial clk_camera_in = 1'b0;
    always #5 clk_camera_in = ~clk_camera_in;

    always @(negedge clk_camera_in) begin
        if (beat_out) tick_cnt++;
        if (lost_out) lost_cnt++;
    end

    task automatic nxt();
        @(negedge clk_camera_in);
        #1;
    endtask

    // Edge lands gap cycles after the previous one; outputs captured one cycle after the edge.
    task automatic beat_after(input int gap);
        repeat (gap - 1) nxt();
        beat_in = 1'b1;
        nxt();
        acc_s   = beat_accepted_out;
        bo_s    = beat_out;
        pv_s    = period_valid_out;
        po_s    = period_out;
        beat_in = 1'b0;
    endtask

    task automatic test_reset();
        int t0, l0;
        rst_in  = 1'b1;
        beat_in = 1'b0;
        repeat (3) nxt();
        n_cmp++; if (period_out !== 8'd0) begin n_bad++; $display("FAIL reset_period got=%0d want=0", period_out); end
        n_cmp++; if (period_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", period_valid_out); end
        n_cmp++; if (beat_accepted_out !== 1'b0) begin n_bad++; $display("FAIL reset_accepted got=%0b want=0", beat_accepted_out); end
        n_cmp++; if (beat_out !== 1'b0) begin n_bad++; $display("FAIL reset_beat got=%0b want=0", beat_out); end
        n_cmp++; if (lost_out !== 1'b0) begin n_bad++; $display("FAIL reset_lost got=%0b want=0", lost_out); end
        rst_in = 1'b0;
        t0 = tick_cnt;
        l0 = lost_cnt;
        repeat (50) nxt();
        n_cmp++; if (lost_cnt - l0 !== 0) begin n_bad++; $display("FAIL idle_lost got=%0d want=0", lost_cnt - l0); end
        n_cmp++; if (tick_cnt - t0 !== 0) begin n_bad++; $display("FAIL idle_ticks got=%0d want=0", tick_cnt - t0); end
        n_cmp++; if (period_valid_out !== 1'b0) begin n_bad++; $display("FAIL idle_valid got=%0b want=0", period_valid_out); end
        n_cmp++; if (period_out !== 8'd0) begin n_bad++; $display("FAIL idle_period got=%0d want=0", period_out); end
    endtask

    task automatic test_lock();
        int t0;
        t0 = tick_cnt;
        for (int i = 0; i < 6; i++) begin
            beat_after(10);
            n_cmp++; if (acc_s !== 1'b1) begin n_bad++; $display("FAIL lock_accept[%0d] got=%0b want=1", i, acc_s); end
            if (i == 3) begin
                n_cmp++; if (pv_s !== 1'b0) begin n_bad++; $display("FAIL lock_valid_early got=%0b want=0", pv_s); end
            end
            if (i == 4) begin
                n_cmp++; if (pv_s !== 1'b1) begin n_bad++; $display("FAIL lock_valid got=%0b want=1", pv_s); end
                n_cmp++; if (po_s !== 8'd10) begin n_bad++; $display("FAIL lock_period got=%0d want=10", po_s); end
                n_cmp++; if (bo_s !== 1'b0) begin n_bad++; $display("FAIL lock_first_tick got=%0b want=0", bo_s); end
            end
            if (i == 5) begin
                n_cmp++; if (bo_s !== 1'b1) begin n_bad++; $display("FAIL lock_tick got=%0b want=1", bo_s); end
            end
        end
        n_cmp++; if (tick_cnt - t0 !== 1) begin n_bad++; $display("FAIL lock_tick_count got=%0d want=1", tick_cnt - t0); end
    endtask

    task automatic test_bounce();
        int t0;
        beat_after(10);
        n_cmp++; if (acc_s !== 1'b1) begin n_bad++; $display("FAIL bounce_pre_accept got=%0b want=1", acc_s); end
        n_cmp++; if (bo_s !== 1'b1) begin n_bad++; $display("FAIL bounce_pre_tick got=%0b want=1", bo_s); end
        t0 = tick_cnt;
        beat_after(2);
        n_cmp++; if (acc_s !== 1'b0) begin n_bad++; $display("FAIL bounce_accept got=%0b want=0", acc_s); end
        n_cmp++; if (bo_s !== 1'b0) begin n_bad++; $display("FAIL bounce_tick got=%0b want=0", bo_s); end
        n_cmp++; if (po_s !== 8'd10) begin n_bad++; $display("FAIL bounce_period got=%0d want=10", po_s); end
        beat_after(8);
        n_cmp++; if (acc_s !== 1'b1) begin n_bad++; $display("FAIL bounce_next_accept got=%0b want=1", acc_s); end
        n_cmp++; if (bo_s !== 1'b1) begin n_bad++; $display("FAIL bounce_next_tick got=%0b want=1", bo_s); end
        n_cmp++; if (po_s !== 8'd10) begin n_bad++; $display("FAIL bounce_next_period got=%0d want=10", po_s); end
        n_cmp++; if (tick_cnt - t0 !== 1) begin n_bad++; $display("FAIL bounce_tick_count got=%0d want=1", tick_cnt - t0); end
    endtask

    task automatic test_average();
        int gaps [4]   = '{8, 8, 12, 12};
        int exp_po [4] = '{9, 9, 9, 10};
        for (int i = 0; i < 4; i++) begin
            beat_after(gaps[i]);
            n_cmp++; if (acc_s !== 1'b1) begin n_bad++; $display("FAIL avg_accept[%0d] got=%0b want=1", i, acc_s); end
            n_cmp++; if (int'(po_s) !== exp_po[i]) begin n_bad++; $display("FAIL avg_period[%0d] got=%0d want=%0d", i, po_s, exp_po[i]); end
            n_cmp++; if (pv_s !== 1'b1) begin n_bad++; $display("FAIL avg_valid[%0d] got=%0b want=1", i, pv_s); end
        end
    endtask

    task automatic test_timeout();
        int t0, l0;
        l0 = lost_cnt;
        repeat (40) nxt();
        n_cmp++; if (lost_cnt - l0 !== 0) begin n_bad++; $display("FAIL timeout_early got=%0d want=0", lost_cnt - l0); end
        n_cmp++; if (period_valid_out !== 1'b1) begin n_bad++; $display("FAIL timeout_valid_before got=%0b want=1", period_valid_out); end
        nxt();
        n_cmp++; if (lost_out !== 1'b1) begin n_bad++; $display("FAIL timeout_lost got=%0b want=1", lost_out); end
        n_cmp++; if (period_valid_out !== 1'b0) begin n_bad++; $display("FAIL timeout_valid got=%0b want=0", period_valid_out); end
        n_cmp++; if (period_out !== 8'd10) begin n_bad++; $display("FAIL timeout_period_hold got=%0d want=10", period_out); end
        t0 = tick_cnt;
        nxt();
        n_cmp++; if (lost_out !== 1'b0) begin n_bad++; $display("FAIL timeout_lost_width got=%0b want=0", lost_out); end
        repeat (20) nxt();
        n_cmp++; if (tick_cnt - t0 !== 0) begin n_bad++; $display("FAIL timeout_ticks got=%0d want=0", tick_cnt - t0); end
        n_cmp++; if (lost_cnt - l0 !== 1) begin n_bad++; $display("FAIL timeout_lost_count got=%0d want=1", lost_cnt - l0); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            beat_after(10);
            n_cmp++; if (acc_s !== 1'b1) begin n_bad++; $display("FAIL relock_accept[%0d] got=%0b want=1", i, acc_s); end
            if (i == 4) begin
                n_cmp++; if (pv_s !== 1'b1) begin n_bad++; $display("FAIL relock_valid got=%0b want=1", pv_s); end
                n_cmp++; if (po_s !== 8'd10) begin n_bad++; $display("FAIL relock_period got=%0d want=10", po_s); end
            end
            if (i == 5) begin
                n_cmp++; if (bo_s !== 1'b1) begin n_bad++; $display("FAIL relock_tick got=%0b want=1", bo_s); end
            end
        end
        rst_in = 1'b1;
        #1;
        n_cmp++; if (period_valid_out !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%0b want=0", period_valid_out); end
        n_cmp++; if (beat_out !== 1'b0) begin n_bad++; $display("FAIL arst_beat got=%0b want=0", beat_out); end
        n_cmp++; if (beat_accepted_out !== 1'b0) begin n_bad++; $display("FAIL arst_accepted got=%0b want=0", beat_accepted_out); end
        n_cmp++; if (period_out !== 8'd0) begin n_bad++; $display("FAIL arst_period got=%0d want=0", period_out); end
        nxt();
        rst_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat_after(10);
            n_cmp++; if (acc_s !== 1'b1) begin n_bad++; $display("FAIL post_rst_accept[%0d] got=%0b want=1", i, acc_s); end
            if (i == 3) begin
                n_cmp++; if (pv_s !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid_early got=%0b want=0", pv_s); end
            end
            if (i == 4) begin
                n_cmp++; if (pv_s !== 1'b1) begin n_bad++; $display("FAIL post_rst_valid got=%0b want=1", pv_s); end
                n_cmp++; if (po_s !== 8'd10) begin n_bad++; $display("FAIL post_rst_period got=%0d want=10", po_s); end
            end
        end
    endtask

    initial begin
        rst_in  = 1'b1;
        beat_in = 1'b0;
        test_reset();
        test_lock();
        test_bounce();
        test_average();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
